multi_pop_fifo: RTL and testbench

- Single-push, multi-pop FIFO: one word may be accepted per cycle, and up to POP_WIDTH words are presented in parallel at the output.
- The consumer may take any prefix of the presented words.
- It is the drain-side counterpart of the multi-push FIFO. It sits between a narrow producer (e.g. a fetch/byte stream) and a wide consumer (e.g. a multi-issue decoder or dispatch stage).

---
 rtl/fifo_pkg.sv | 14 +
 rtl/multi_pop_fifo.sv | 99 +++++++++
 tb/tb_multi_pop_fifo.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers used by the multi-push and multi-pop FIFOs.
package fifo_pkg;

    // Modular pointer add for non-power-of-two depths; inc must not exceed depth.
    function automatic int unsigned ptr_add(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned depth);
        int unsigned sum;
        sum = ptr + inc;
        if (sum >= depth) sum = sum - depth;
        return sum;
    endfunction

endpackage

// File: rtl/multi_pop_fifo.sv
// Single-push, multi-pop FIFO: one word in per cycle, up to POP_WIDTH oldest
// words presented in parallel; the consumer takes any prefix of them.
module multi_pop_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned POP_WIDTH  = 4,
    parameter int unsigned ELEMENTS   = 15
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH-1:0]             din,
    input  logic                              din_valid,
    output logic                              din_ready,
    output logic [DATA_WIDTH*POP_WIDTH-1:0]   dout,
    output logic [$clog2(POP_WIDTH):0]        dout_valid_ct,
    input  logic [$clog2(POP_WIDTH):0]        dout_ready_ct
);

    localparam int unsigned PTR_W = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
    localparam int unsigned CNT_W = $clog2(ELEMENTS + 1);
    localparam int unsigned VCT_W = $clog2(POP_WIDTH) + 1;

    if (POP_WIDTH < 1 || ELEMENTS < POP_WIDTH) begin : g_param_check
        $error("multi_pop_fifo: requires POP_WIDTH >= 1 and ELEMENTS >= POP_WIDTH");
    end

    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_mem [ELEMENTS];

    logic             w_empty;
    logic [VCT_W-1:0] w_valid_ct;
    logic [VCT_W-1:0] w_pops;
    logic [VCT_W-1:0] w_rd_pops;
    logic             w_push;
    logic             w_wr_en;

    assign w_empty   = (r_count == '0);
    assign din_ready = rst_n & (r_count < CNT_W'(ELEMENTS));
    assign w_push    = din_valid & din_ready;

    always_comb begin
        w_valid_ct = '0;
        if (!rst_n)
            w_valid_ct = '0;
        else if (w_empty)
            w_valid_ct = VCT_W'(din_valid);
        else if (r_count >= CNT_W'(POP_WIDTH))
            w_valid_ct = VCT_W'(POP_WIDTH);
        else
            w_valid_ct = VCT_W'(r_count);
    end

    assign dout_valid_ct = w_valid_ct;
    assign w_pops        = (dout_ready_ct < w_valid_ct) ? dout_ready_ct : w_valid_ct;

    // When empty, any pop is the bypassed din: it is never written and frees no slot.
    assign w_wr_en   = w_push & ~(w_empty & (w_pops != '0));
    assign w_rd_pops = w_empty ? '0 : w_pops;

    for (genvar i = 0; i < POP_WIDTH; i++) begin : g_lane
        localparam int unsigned LANE = i;
        logic [PTR_W-1:0]      w_idx;
        logic [DATA_WIDTH-1:0] w_word;

        assign w_idx = PTR_W'(ptr_add(32'(r_rd_ptr), LANE, ELEMENTS));

        always_comb begin
            w_word = r_mem[w_idx];
            if (!rst_n)
                w_word = '0;
            else if (LANE == 0 && w_empty)
                w_word = din;
        end

        assign dout[i*DATA_WIDTH +: DATA_WIDTH] = w_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= PTR_W'(ptr_add(32'(r_wr_ptr), 32'd1, ELEMENTS));
            r_rd_ptr <= PTR_W'(ptr_add(32'(r_rd_ptr), 32'(w_rd_pops), ELEMENTS));
            r_count  <= r_count + CNT_W'(w_wr_en) - CNT_W'(w_rd_pops);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: tb/tb_multi_pop_fifo.sv
// Self-checking bench for multi_pop_fifo against a queue-based reference model.
module tb_multi_pop_fifo;

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 4;
    localparam int unsigned EL = 15;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [DW*PW-1:0] dout;
    logic [2:0]    dout_valid_ct;
    logic [2:0]    dout_ready_ct;

    int checks;
    int errors;
    logic [DW-1:0] q[$];

    multi_pop_fifo #(.DATA_WIDTH(DW), .POP_WIDTH(PW), .ELEMENTS(EL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .dout         (dout),
        .dout_valid_ct(dout_valid_ct),
        .dout_ready_ct(dout_ready_ct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_vct();
        if (!rst_n) return 0;
        if (q.size() == 0) return int'(din_valid);
        return (q.size() < PW) ? q.size() : PW;
    endfunction

    function automatic logic [DW-1:0] exp_lane(input int i);
        if (q.size() == 0) return din;
        return q[i];
    endfunction

    function automatic logic [DW-1:0] lane(input int i);
        return dout[i*DW +: DW];
    endfunction

    // Advance one clock edge and apply the edge's effect to the model.
    task automatic step();
        int v;
        int p;
        bit room;
        @(posedge clk);
        if (rst_n) begin
            v = exp_vct();
            p = (int'(dout_ready_ct) < v) ? int'(dout_ready_ct) : v;
            room = (q.size() < EL);
            if (q.size() == 0) begin
                if (p == 0 && din_valid) q.push_back(din);
            end else begin
                repeat (p) void'(q.pop_front());
                if (din_valid && room) q.push_back(din);
            end
        end else begin
            q.delete();
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din_valid = 1'b1; din = 32'hA5; dout_ready_ct = '0;
        #12;
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0h expected 0", din_ready); end
        checks++; if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL reset_vct got %0d expected 0", dout_valid_ct); end
        rst_n = 1'b1;
        #2;
        checks++; if (dout_valid_ct !== 3'd1) begin errors++; $display("FAIL bypass_vct got %0d expected 1", dout_valid_ct); end
        checks++; if (lane(0) !== 32'hA5) begin errors++; $display("FAIL bypass_lane0 got %0h expected a5", lane(0)); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready got %0h expected 1", din_ready); end
        dout_ready_ct = 3'd1;
        step();
        din_valid = 1'b0; dout_ready_ct = '0;
        #2;
        checks++; if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL bypass_consumed_vct got %0d expected 0", dout_valid_ct); end
    endtask

    task automatic test_fill_partial_pop();
        for (int k = 0; k < 6; k++) begin
            din_valid = 1'b1; din = 32'(k); dout_ready_ct = '0;
            #2;
            checks++; if (int'(dout_valid_ct) != exp_vct()) begin errors++; $display("FAIL push_vct got %0d expected %0d", dout_valid_ct, exp_vct()); end
            step();
        end
        din_valid = 1'b0;
        #2;
        checks++; if (dout_valid_ct !== 3'd4) begin errors++; $display("FAIL sat_vct got %0d expected 4", dout_valid_ct); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (lane(i) !== 32'(i)) begin errors++; $display("FAIL sat_lane%0d got %0h expected %0h", i, lane(i), i); end
        end
        dout_ready_ct = 3'd3;
        step();
        dout_ready_ct = '0;
        #2;
        checks++; if (dout_valid_ct !== 3'd3) begin errors++; $display("FAIL pop3_vct got %0d expected 3", dout_valid_ct); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (lane(i) !== 32'(i + 3)) begin errors++; $display("FAIL pop3_lane%0d got %0h expected %0h", i, lane(i), i + 3); end
        end
        dout_ready_ct = 3'd4;
        step();
        dout_ready_ct = '0;
    endtask

    task automatic test_full();
        for (int k = 0; k < EL; k++) begin
            din_valid = 1'b1; din = 32'h1000 + 32'(k); dout_ready_ct = '0;
            step();
        end
        din_valid = 1'b1; din = 32'hDEAD; dout_ready_ct = 3'd2;
        #2;
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0h expected 0", din_ready); end
        checks++; if (dout_valid_ct !== 3'd4) begin errors++; $display("FAIL full_vct got %0d expected 4", dout_valid_ct); end
        step();
        dout_ready_ct = '0;
        #2;
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL after_pop_ready got %0h expected 1", din_ready); end
        checks++; if (lane(0) !== 32'h1002) begin errors++; $display("FAIL after_pop_lane0 got %0h expected 1002", lane(0)); end
        step();
        din_valid = 1'b0;
        checks++; if (q.size() != 14 || q[13] !== 32'hDEAD) begin errors++; $display("FAIL model_dead_tail got %0d expected 14", q.size()); end
        dout_ready_ct = 3'd4;
        for (int n = 0; n < 6; n++) begin
            #2;
            checks++; if (int'(dout_valid_ct) != exp_vct()) begin errors++; $display("FAIL drain_vct got %0d expected %0d", dout_valid_ct, exp_vct()); end
            for (int i = 0; i < exp_vct(); i++) begin
                checks++; if (lane(i) !== exp_lane(i)) begin errors++; $display("FAIL drain_lane%0d got %0h expected %0h", i, lane(i), exp_lane(i)); end
            end
            step();
        end
        dout_ready_ct = '0;
    endtask

    task automatic test_wrap();
        rst_n = 1'b0; #3; rst_n = 1'b1;
        q.delete();
        for (int k = 0; k < 13; k++) begin
            din_valid = 1'b1; din = 32'h200 + 32'(k); dout_ready_ct = '0;
            step();
        end
        din_valid = 1'b0; dout_ready_ct = 3'd4;
        while (q.size() != 0) step();
        for (int k = 0; k < 6; k++) begin
            din_valid = 1'b1; din = 32'd100 + 32'(k); dout_ready_ct = '0;
            step();
        end
        din_valid = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            checks++; if (lane(i) !== 32'(100 + i)) begin errors++; $display("FAIL wrap_lane%0d got %0d expected %0d", i, lane(i), 100 + i); end
        end
        dout_ready_ct = 3'd4;
        step();
        dout_ready_ct = '0;
        #2;
        checks++; if (dout_valid_ct !== 3'd2) begin errors++; $display("FAIL wrap_vct got %0d expected 2", dout_valid_ct); end
        checks++; if (lane(0) !== 32'd104 || lane(1) !== 32'd105) begin errors++; $display("FAIL wrap_tail got %0d,%0d expected 104,105", lane(0), lane(1)); end
        dout_ready_ct = 3'd4;
        step();
        dout_ready_ct = '0;
    endtask

    task automatic test_over_request();
        for (int k = 0; k < 2; k++) begin
            din_valid = 1'b1; din = 32'h300 + 32'(k); dout_ready_ct = '0;
            step();
        end
        din_valid = 1'b0; dout_ready_ct = 3'd4;
        #2;
        checks++; if (dout_valid_ct !== 3'd2) begin errors++; $display("FAIL over_vct got %0d expected 2", dout_valid_ct); end
        step();
        dout_ready_ct = '0;
        #2;
        checks++; if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL over_empty_vct got %0d expected 0", dout_valid_ct); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL over_ready got %0h expected 1", din_ready); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 9; k++) begin
            din_valid = 1'b1; din = 32'h400 + 32'(k); dout_ready_ct = '0;
            step();
        end
        #2;
        checks++; if (dout_valid_ct !== 3'd4) begin errors++; $display("FAIL pre_reset_vct got %0d expected 4", dout_valid_ct); end
        rst_n = 1'b0;
        #1;
        checks++; if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL async_vct got %0d expected 0", dout_valid_ct); end
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL async_ready got %0h expected 0", din_ready); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL async_dout got %0h expected 0", dout); end
        din_valid = 1'b0;
        q.delete();
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL post_reset_vct got %0d expected 0", dout_valid_ct); end
        step();
        #2;
        checks++; if (dout_valid_ct !== 3'd0) begin errors++; $display("FAIL post_reset_stale got %0d expected 0", dout_valid_ct); end
    endtask

    task automatic test_random();
        int unsigned push_pct;
        for (int n = 0; n < 600; n++) begin
            push_pct = ((n / 50) % 2 == 0) ? 85 : 30;
            din_valid     = ($urandom_range(0, 99) < push_pct);
            din           = $urandom;
            dout_ready_ct = 3'($urandom_range(0, 4));
            #2;
            checks++; if (din_ready !== (q.size() < EL)) begin errors++; $display("FAIL rnd_ready cyc %0d got %0h expected %0h", n, din_ready, q.size() < EL); end
            checks++; if (int'(dout_valid_ct) != exp_vct()) begin errors++; $display("FAIL rnd_vct cyc %0d got %0d expected %0d", n, dout_valid_ct, exp_vct()); end
            for (int i = 0; i < exp_vct(); i++) begin
                checks++; if (lane(i) !== exp_lane(i)) begin errors++; $display("FAIL rnd_lane%0d cyc %0d got %0h expected %0h", i, n, lane(i), exp_lane(i)); end
            end
            step();
        end
        din_valid = 1'b0; dout_ready_ct = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill_partial_pop();
        test_full();
        test_wrap();
        test_over_request();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
